// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single outstanding imem request, one-entry
// instruction buffer, redirect with drain of an in-flight request.
module if_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        inst_valid,
  output logic        if_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_reg;
  logic [31:0] r_inst_buf;
  logic [31:0] r_drain_addr;

  state_t      w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_nxt_buf;
  logic [31:0] w_nxt_drain;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_advance;

  logic        w_nxt_req;
  logic [31:0] w_nxt_addr;
  logic        w_nxt_valid;
  logic [31:0] w_nxt_instr;
  logic [31:0] w_nxt_pc_out;

  assign w_target   = branch_addr & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc_reg + 32'd4;
  assign w_advance  = ~freeze & ~mem_freeze;

  // next-state and next pc/buffer; redirect outranks every stall
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc_reg;
    w_nxt_buf   = r_inst_buf;
    w_nxt_drain = r_drain_addr;
    unique case (r_state)
      IDLE: begin
        w_nxt_state = REQ;
        if (branch_taken)
          w_nxt_pc = w_target;
      end
      REQ: begin
        if (branch_taken) begin
          w_nxt_pc = w_target;
          if (imem_ack) begin
            w_nxt_state = REQ;
          end else begin
            w_nxt_state = DRAIN;
            w_nxt_drain = r_pc_reg;
          end
        end else if (imem_ack) begin
          w_nxt_buf   = imem_rdata;
          w_nxt_state = READY;
        end
      end
      READY: begin
        if (branch_taken) begin
          w_nxt_pc    = w_target;
          w_nxt_state = REQ;
        end else if (w_advance) begin
          w_nxt_pc    = w_pc_plus4;
          w_nxt_state = REQ;
        end
      end
      DRAIN: begin
        if (branch_taken)
          w_nxt_pc = w_target;
        if (imem_ack)
          w_nxt_state = REQ;
      end
    endcase
  end

  // output values for the upcoming state, so outputs leave flops
  always_comb begin
    w_nxt_req    = 1'b0;
    w_nxt_addr   = 32'd0;
    w_nxt_valid  = 1'b0;
    w_nxt_instr  = 32'd0;
    w_nxt_pc_out = 32'd0;
    unique case (w_nxt_state)
      IDLE: begin
        w_nxt_req = 1'b0;
      end
      REQ: begin
        w_nxt_req  = 1'b1;
        w_nxt_addr = w_nxt_pc;
      end
      READY: begin
        w_nxt_valid  = 1'b1;
        w_nxt_instr  = w_nxt_buf;
        w_nxt_pc_out = w_nxt_pc + 32'd4;
      end
      DRAIN: begin
        w_nxt_req  = 1'b1;
        w_nxt_addr = w_nxt_drain;
      end
    endcase
  end

  // fetch FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc_reg     <= 32'd0;
      r_inst_buf   <= 32'd0;
      r_drain_addr <= 32'd0;
      imem_req     <= 1'b0;
      imem_addr    <= 32'd0;
      inst_valid   <= 1'b0;
      Instruction  <= 32'd0;
      PC           <= 32'd0;
      if_stall     <= 1'b1;
    end else begin
      r_state      <= w_nxt_state;
      r_pc_reg     <= w_nxt_pc;
      r_inst_buf   <= w_nxt_buf;
      r_drain_addr <= w_nxt_drain;
      imem_req     <= w_nxt_req;
      imem_addr    <= w_nxt_addr;
      inst_valid   <= w_nxt_valid;
      Instruction  <= w_nxt_instr;
      PC           <= w_nxt_pc_out;
      if_stall     <= ~w_nxt_valid;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed imem handshakes, expected
// instructions queued by the driver and checked by a monitor.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        mem_freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic        if_stall;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_prev = 1'b0;
  exp_t mon_e;

  if_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .mem_freeze(mem_freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .Instruction(Instruction),
    .inst_valid(inst_valid),
    .if_stall(if_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    q.push_back(e);
  endtask

  // monitor: each new valid instruction must match the queue head
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && !mon_prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got instr %h pc %h expected none",
                 Instruction, PC);
      end else begin
        mon_e = q.pop_front();
        chk("mon_instr", Instruction, mon_e.ins);
        chk("mon_pc", PC, mon_e.pc);
        chk("mon_stall", {31'd0, if_stall}, 32'd0);
      end
    end
    mon_prev = (inst_valid === 1'b1);
  end

  initial begin
    // reset values
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_stall", {31'd0, if_stall}, 32'd1);
    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // zero-wait ack at address 0
    step();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2001_0005;
    push(32'h2001_0005, 32'h4);
    step();
    imem_ack = 1'b0;
    chk("t1_req_ready", {31'd0, imem_req}, 32'd0);

    // freeze two cycles in READY
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("frz_valid", {31'd0, inst_valid}, 32'd1);
      chk("frz_instr", Instruction, 32'h2001_0005);
      chk("frz_pc", PC, 32'h4);
      chk("frz_req", {31'd0, imem_req}, 32'd0);
    end
    freeze = 1'b0;
    step();
    chk("frz_next_req", {31'd0, imem_req}, 32'd1);
    chk("frz_next_addr", imem_addr, 32'h4);

    // ack delayed three cycles
    for (int i = 0; i < 4; i++) begin
      chk("dly_req", {31'd0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h4);
      chk("dly_stall", {31'd0, if_stall}, 32'd1);
      chk("dly_instr", Instruction, 32'd0);
      if (i == 3) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        push(32'h00A0_0093, 32'h8);
      end
      step();
    end
    imem_ack = 1'b0;
    step();
    chk("adv_addr", imem_addr, 32'h8);

    // redirect while request outstanding, ack two cycles later
    branch_taken = 1'b1;
    branch_addr  = 32'h43;
    step();
    branch_taken = 1'b0;
    chk("drn_req", {31'd0, imem_req}, 32'd1);
    chk("drn_addr", imem_addr, 32'h8);
    chk("drn_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("drn_addr2", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("drn_new_req", {31'd0, imem_req}, 32'd1);
    chk("drn_new_addr", imem_addr, 32'h40);
    chk("drn_no_valid", {31'd0, inst_valid}, 32'd0);
    imem_rdata = 32'h1234_5678;
    push(32'h1234_5678, 32'h44);
    step();
    imem_ack = 1'b0;

    // branch and mem_freeze together in READY; target wraps next
    branch_taken = 1'b1;
    mem_freeze   = 1'b1;
    branch_addr  = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    mem_freeze   = 1'b0;
    chk("bmf_req", {31'd0, imem_req}, 32'd1);
    chk("bmf_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    push(32'h0000_0013, 32'h0);
    step();
    imem_ack = 1'b0;
    chk("wrap_pc", PC, 32'h0);
    step();
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);

    // reset asserted mid-drain
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    branch_taken = 1'b0;
    chk("rd_drain_addr", imem_addr, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    chk("rd_stall", {31'd0, if_stall}, 32'd1);
    step();
    rst = 1'b0;
    chk("rd_idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("rd_first_req", {31'd0, imem_req}, 32'd1);
    chk("rd_first_addr", imem_addr, 32'h0);

    // redirect with ack in the same cycle discards the data
    imem_ack     = 1'b1;
    imem_rdata   = 32'hBAD0_BAD0;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("bra_addr", imem_addr, 32'h100);
    chk("bra_valid", {31'd0, inst_valid}, 32'd0);
    imem_rdata = 32'h2222_2222;
    push(32'h2222_2222, 32'h104);
    step();
    imem_ack = 1'b0;
    step();
    chk("bra_next_addr", imem_addr, 32'h104);
    step();
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have a clock input, clk: in, 1 bit, all state updates on rising edge.
REQ-002 The block SHALL have a reset input, rst: in, 1 bit, asynchronous, active-high.
REQ-003 The block SHALL have a hazard-stall input, freeze: in, 1 bit.
REQ-004 The block SHALL have a data-memory-stall input, mem_freeze: in, 1 bit.
REQ-005 The block SHALL have a redirect request input, branch_taken: in, 1 bit, single-cycle pulse.
REQ-006 The block SHALL have a redirect target input, branch_addr: in, 32 bits.
REQ-007 The block SHALL have an instruction memory request output, imem_req: out, 1 bit.
REQ-008 The block SHALL have an instruction memory address output, imem_addr: out, 32 bits, word-aligned.
REQ-009 The block SHALL have a memory acknowledge input, imem_ack: in, 1 bit, single-cycle, rdata valid in that cycle.
REQ-010 The block SHALL have a memory read data input, imem_rdata: in, 32 bits.
REQ-011 The block SHALL have a next-PC output, PC: out, 32 bits, equal to fetched address + 4.
REQ-012 The block SHALL have a fetched instruction output, Instruction: out, 32 bits.
REQ-013 The block SHALL have an instruction valid output, inst_valid: out, 1 bit.
REQ-014 The block SHALL have a fetch stall output, if_stall: out, 1 bit, equal to ~inst_valid.

Function
REQ-015 The block SHALL keep an internal pc_reg (32 bits) and a 32-bit instruction buffer inst_buf.
REQ-016 The block SHALL implement four states: IDLE, REQ, READY, DRAIN.
REQ-017 In IDLE the block SHALL hold imem_req=0, SHALL ignore imem_ack, and SHALL move to REQ on the next cycle unconditionally.
REQ-018 In REQ the block SHALL assert imem_req=1 with imem_addr=pc_reg, holding the address stable until imem_ack.
REQ-019 On imem_ack in REQ (zero-wait allowed, same cycle as first req), the block SHALL load inst_buf<=imem_rdata and move to READY.
REQ-020 In READY the block SHALL drive inst_valid=1, Instruction=inst_buf and PC=pc_reg+4, with imem_req=0.
REQ-021 In READY with advance=~freeze&~mem_freeze, the block SHALL set pc_reg<=pc_reg+4 and move to REQ.
REQ-022 In READY with freeze or mem_freeze high, the block SHALL hold state, pc_reg and all outputs.
REQ-023 Whenever inst_valid=0, the block SHALL drive Instruction=0 and PC=0 (bubble to downstream register).
REQ-024 pc_reg+4 SHALL wrap modulo 2^32, so 0xFFFFFFFC advances to 0x00000000.
REQ-025 branch_taken SHALL have priority over freeze and mem_freeze in every state.
REQ-026 On branch_taken, the block SHALL load pc_reg<={branch_addr[31:2],2'b00}.
REQ-027 On branch_taken in IDLE, READY, or in REQ with imem_ack in the same cycle, the block SHALL discard any returned data and move to REQ.
REQ-028 On branch_taken in REQ without imem_ack, the block SHALL move to DRAIN.
REQ-029 In DRAIN the block SHALL keep imem_req=1 with the old address, SHALL discard data on imem_ack, and SHALL then move to REQ at the new pc_reg.
REQ-030 A further branch_taken during DRAIN SHALL update pc_reg only, with the state staying DRAIN.
REQ-031 Minimum fetch throughput SHALL be one instruction per 2 cycles (REQ+ack, READY+advance).

Reset
REQ-032 While rst is high, the block SHALL hold state=IDLE, pc_reg=0, inst_buf=0, and outputs imem_req=0, imem_addr=0, PC=0, Instruction=0, inst_valid=0, if_stall=1.
REQ-033 Assertion of rst mid-request or mid-drain SHALL abandon the transaction immediately, and the first request after release SHALL be to address 0 in the second cycle.

Verification
REQ-034 Bench: rst release, zero-wait ack with rdata 0x20010005 at addr 0 -> next cycle inst_valid=1, Instruction=0x20010005, PC=0x4.
REQ-035 Bench: ack delayed 3 cycles -> imem_req high with addr stable for 4 cycles, if_stall=1 and Instruction=0 throughout.
REQ-036 Bench: freeze high 2 cycles in READY -> outputs held and imem_req=0, then after release the next req is to addr 0x4.
REQ-037 Bench: branch_taken with branch_addr 0x43 in REQ and ack 2 cycles later -> DRAIN, data discarded, next req to addr 0x40, no valid instruction from the old address.
REQ-038 Bench: branch_taken and mem_freeze together in READY -> branch wins, next cycle req to the branch target.
REQ-039 Bench: pc_reg=0xFFFFFFFC fetched and advanced -> PC output 0x0, next req to addr 0x0.
